// File: rtl/instr_fetch.sv
// instr_fetch: watches the PC, reads a synchronous ROM and holds the fetched instruction
module instr_fetch #(
  parameter int D = 12,
  parameter int W = 9,
  parameter int CYCLES = 12,
  parameter logic [W-1:0] HALT_OP = 9'h1FF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic [W-1:0] rom_data,
  output logic [D-1:0] rom_addr,
  output logic [W-1:0] instr,
  output logic         instr_valid,
  output logic [3:0]   phase,
  output logic         halted,
  output logic [15:0]  fetch_count
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] CAPT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] HALT = 3'd4;
  localparam logic [3:0] PMAX = 4'(CYCLES - 1);

  logic [2:0]   state_q, state_d;
  logic [D-1:0] rom_addr_q, rom_addr_d, last_pc_q, last_pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic         valid_q, valid_d, halted_q, halted_d, pc_seen_q, pc_seen_d;
  logic [3:0]   phase_q, phase_d;
  logic [15:0]  count_q, count_d;
  logic         new_pc, load, capture, is_halt;

  // Any non-halted state restarts on a new PC; CAPT captures only when the PC stayed put
  always_comb begin
    new_pc     = !pc_seen_q || prog_ctr != last_pc_q;
    load       = new_pc && state_q != HALT;
    capture    = state_q == CAPT && !new_pc;
    is_halt    = rom_data == HALT_OP;
    state_d    = load ? WAIT : state_q == WAIT ? CAPT : capture ? (is_halt ? HALT : HOLD) : state_q;
    rom_addr_d = load ? prog_ctr : rom_addr_q;
    last_pc_d  = load ? prog_ctr : last_pc_q;
    pc_seen_d  = pc_seen_q | load;
    instr_d    = capture ? rom_data : instr_q;
    valid_d    = capture | (valid_q & !load);
    phase_d    = (capture || load) ? 4'd0 : state_q == HOLD ? (phase_q == PMAX ? phase_q : phase_q + 4'd1) : phase_q;
    halted_d   = halted_q | (capture & is_halt);
    count_d    = count_q + 16'(capture);
  end

  // State registers with synchronous reset that discards any in-flight fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      last_pc_q  <= '0;
      pc_seen_q  <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      phase_q    <= '0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      last_pc_q  <= last_pc_d;
      pc_seen_q  <= pc_seen_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign phase       = phase_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch timing, restarts, halt, reset and counter wrap
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  logic [8:0]  rom_data;
  logic [11:0] rom_addr;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [3:0]  phase;
  logic        halted;
  logic [15:0] fetch_count;
  logic [8:0]  rom [4096];
  int          n_chk = 0;
  int          n_pass = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .rom_data(rom_data),
    .rom_addr(rom_addr), .instr(instr), .instr_valid(instr_valid),
    .phase(phase), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data for an address sampled at one edge is visible after it
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rom_addr"}, 32'(rom_addr), 0);
    check({tag, ".instr"}, 32'(instr), 0);
    check({tag, ".valid"}, 32'(instr_valid), 0);
    check({tag, ".phase"}, 32'(phase), 0);
    check({tag, ".halted"}, 32'(halted), 0);
    check({tag, ".count"}, 32'(fetch_count), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    rom[0] = 9'h012; rom[1] = 9'h0A5; rom[3] = 9'h1FF; rom[4] = 9'h0C4;
    rom[5] = 9'h055; rom[6] = 9'h066; rom[7] = 9'h077; rom[8] = 9'h088;
    rom[9] = 9'h133;
    reset = 1'b1;
    prog_ctr = 12'd0;
    step(2);
    check_zero("rst");
    reset = 1'b0;
    step(1);
    check("e1.rom_addr", 32'(rom_addr), 0);
    check("e1.valid", 32'(instr_valid), 0);
    step(1);
    check("e2.valid", 32'(instr_valid), 0);
    step(1);
    check("e3.instr", 32'(instr), 32'h012);
    check("e3.valid", 32'(instr_valid), 1);
    check("e3.phase", 32'(phase), 0);
    check("e3.count", 32'(fetch_count), 1);
    step(11);
    check("phase11", 32'(phase), 11);
    step(1);
    check("phase_sat", 32'(phase), 11);
    check("hold_valid", 32'(instr_valid), 1);
    prog_ctr = 12'd1;
    step(1);
    check("pc1.gap1", 32'(instr_valid), 0);
    check("pc1.rom_addr", 32'(rom_addr), 1);
    check("pc1.old_instr", 32'(instr), 32'h012);
    step(1);
    check("pc1.gap2", 32'(instr_valid), 0);
    step(1);
    check("pc1.valid", 32'(instr_valid), 1);
    check("pc1.instr", 32'(instr), 32'h0A5);
    check("pc1.count", 32'(fetch_count), 2);
    check("pc1.phase", 32'(phase), 0);
    prog_ctr = 12'd5;
    step(1);
    check("wr.rom_addr5", 32'(rom_addr), 5);
    prog_ctr = 12'd9;
    step(1);
    check("wr.rom_addr9", 32'(rom_addr), 9);
    check("wr.valid_a", 32'(instr_valid), 0);
    step(1);
    check("wr.valid_b", 32'(instr_valid), 0);
    step(1);
    check("wr.instr", 32'(instr), 32'h133);
    check("wr.count", 32'(fetch_count), 3);
    step(4);
    check("norefetch.count", 32'(fetch_count), 3);
    check("norefetch.valid", 32'(instr_valid), 1);
    prog_ctr = 12'd3;
    step(3);
    check("halt.instr", 32'(instr), 32'h1FF);
    check("halt.halted", 32'(halted), 1);
    check("halt.count", 32'(fetch_count), 4);
    prog_ctr = 12'd4;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("halt.rom_addr", 32'(rom_addr), 3);
      check("halt.frozen", {instr_valid, 3'b0, phase, 7'b0, instr, fetch_count[7:0]}, {1'b1, 3'b0, 4'd0, 7'b0, 9'h1FF, 8'd4});
    end
    reset = 1'b1;
    step(1);
    check_zero("rst_halt");
    reset = 1'b0;
    step(2);
    check("rh.valid", 32'(instr_valid), 0);
    step(1);
    check("rh.valid1", 32'(instr_valid), 1);
    check("rh.instr", 32'(instr), 32'h0C4);
    check("rh.count", 32'(fetch_count), 1);
    prog_ctr = 12'd6;
    step(2);
    check("rc.capt_valid", 32'(instr_valid), 0);
    reset = 1'b1;
    step(1);
    check_zero("rst_capt");
    reset = 1'b0;
    step(2);
    check("rc.valid", 32'(instr_valid), 0);
    step(1);
    check("rc.valid1", 32'(instr_valid), 1);
    check("rc.instr", 32'(instr), 32'h066);
    check("rc.count", 32'(fetch_count), 1);
    prog_ctr = 12'd7;
    step(2);
    prog_ctr = 12'd8;
    step(1);
    check("cr.valid", 32'(instr_valid), 0);
    check("cr.rom_addr", 32'(rom_addr), 8);
    check("cr.count", 32'(fetch_count), 1);
    step(2);
    check("cr.instr", 32'(instr), 32'h088);
    check("cr.count2", 32'(fetch_count), 2);
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    step(1);
    check("wrap.pre", 32'(fetch_count), 32'hFFFF);
    prog_ctr = 12'd1;
    step(3);
    check("wrap.count", 32'(fetch_count), 0);
    check("wrap.instr", 32'(instr), 32'h0A5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
